regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
//
// PURPOSE
//   Parametrised integer register file with NUM_RD registered read ports, one write port and a per-register
//   scoreboard of pending-write bits. It sits between decode/issue and writeback. The issue stage marks a
//   destination register busy, and writeback clears it. Read ports return data plus the source's pending
//   status, so decode can stall on RAW hazards without a separate hazard table.
//
// PARAMETERS
//   XLEN      32   data width of each register
//   NREG      32   number of architectural registers (power of two, >= 2)
//   NUM_RD    2    number of independent read ports (1..4)
//   ZERO_REG  1    1: register 0 reads as 0, ignores writes and is never marked pending
//   (derived) AW = $clog2(NREG), address width
//
// PORTS
//   clk           in   1            clock, all state updates on rising edge
//   rst           in   1            asynchronous, active-high reset
//   rd_en         in   NUM_RD       per-port read enable
//   rd_addr       in   NUM_RD*AW    per-port read address, port i in bits [i*AW +: AW]
//   rd_data       out  NUM_RD*XLEN  per-port registered read data
//   rd_pending    out  NUM_RD       per-port registered pending flag of the addressed register
//   wr_en         in   1            writeback enable
//   wr_addr       in   AW           writeback address
//   wr_data       in   XLEN         writeback data
//   iss_en        in   1            issue: mark iss_addr pending
//   iss_addr      in   AW           destination register of the issuing instruction
//   flush         in   1            clear every pending bit; register contents kept
//   busy_vec      out  NREG         current scoreboard bits, direct from state flops
//   waw_err       out  1            registered one-cycle pulse: issue to a register already pending
//
// BEHAVIOUR
//   Reset (async, takes effect immediately):
//     - all registers = 0, rd_data = 0, rd_pending = 0, busy_vec = 0, waw_err = 0
//     - reset mid-operation discards in-flight reads, writes and issues of that cycle
//   Write: if wr_en and not (ZERO_REG && wr_addr==0), then regs[wr_addr] <= wr_data at the edge.
//   Read port i, 1-cycle latency:
//     - rd_en[i]=1: rd_data[i] and rd_pending[i] update at the next edge
//     - rd_en[i]=0: rd_data[i] and rd_pending[i] hold their previous value
//     - data priority:
//         (1) ZERO_REG && addr==0 -> 0
//         (2) wr_en && wr_addr==addr -> wr_data (write-through bypass)
//         (3) regs[addr]
//     - pending = busy[addr] & ~(wr_en && wr_addr==addr)
//         - same-cycle writeback is seen as cleared
//         - same-cycle issue is NOT seen, because the issuing instruction reads its own sources first
//     - every port uses its own address; all ports are fully independent and may alias
//   Scoreboard next state, in priority order per bit r:
//     1. flush                            -> busy[r] = 0 for all r (overrides issue and write)
//     2. iss_en && iss_addr==r            -> busy[r] = 1 (issue beats same-cycle writeback to same r)
//     3. wr_en && wr_addr==r              -> busy[r] = 0
//     4. otherwise                        -> hold
//     - with ZERO_REG=1, busy[0] stays 0 forever and an issue to 0 is ignored
//     - a writeback to a non-pending register is legal (no error, no state change beyond data)
//   waw_err <= iss_en && !flush && busy[iss_addr] && !(wr_en && wr_addr==iss_addr), excluding reg 0 when ZERO_REG.
//   Widths: all addresses are AW bits; no truncation; wr_data is stored unmodified.
//
// STRUCTURE
//   - package regfile_pkg: default XLEN/NREG, typedef logic [XLEN-1:0] word_t, constant ZERO_ADDR,
//     function aw(n) = $clog2(n)
//   - sub-module regfile_rdport: one read port (zero/bypass/array mux plus pending lookup and output
//     flops), instantiated NUM_RD times in a generate loop
//   - register array and scoreboard flops stay in the top module
//
// TESTING
//   1. Reset: assert rst mid-stream with wr_en=1 to reg 5 -> rd_data/busy_vec/waw_err = 0 immediately;
//      reg 5 reads 0 after release.
//   2. Bypass: wr_en, reg 7 = 0xDEADBEEF and rd_en[0..1] addr 7 in the same cycle -> next cycle both ports
//      read 0xDEADBEEF, rd_pending = 0.
//   3. Zero register: write 0x1234 to reg 0 and iss_en to reg 0 -> reads return 0, busy_vec[0] = 0,
//      waw_err = 0.
//   4. Scoreboard:
//      - issue reg 3 -> busy_vec[3] = 1 next cycle
//      - read reg 3 -> rd_pending = 1
//      - issue reg 3 again -> waw_err pulses one cycle
//      - writeback reg 3 -> busy_vec[3] = 0
//   5. Simultaneous events:
//      - issue and writeback to reg 9 in one cycle -> busy_vec[9] = 1, waw_err = 0
//      - flush with iss_en to reg 4 -> busy_vec = 0
//   6. Port independence (NUM_RD=3): three different addresses, rd_en = 3'b101 -> ports 0 and 2 update,
//      port 1 holds its old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, word type and address-width helper for the register file slice
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_ADDR = 0;
  typedef logic [DEF_XLEN-1:0] word_t;
  function automatic int aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, writeback, issue and scoreboard signals between pipeline and register file
interface regfile_scoreboard_if #(
  parameter int XLEN = regfile_pkg::DEF_XLEN,
  parameter int NREG = regfile_pkg::DEF_NREG,
  parameter int NUM_RD = 2
);
  localparam int AW = regfile_pkg::aw(NREG);
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   flush;
  logic [NREG-1:0]        busy_vec;
  logic                   waw_err;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_pending, busy_vec, waw_err
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_pending, busy_vec, waw_err
  );
endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port with zero-register, write-through bypass and pending lookup
module regfile_rdport import regfile_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int ZERO_REG = 1,
  localparam int AW = aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] busy,
  output logic [XLEN-1:0] data,
  output logic            pending
);
  logic            hit;
  logic [XLEN-1:0] nxt;
  assign hit = wr_en && (wr_addr == addr);
  always_comb nxt = (ZERO_REG != 0 && addr == AW'(ZERO_ADDR)) ? '0 : hit ? wr_data : regs[addr];
  // a same-cycle writeback already counts as resolved for the reader
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      pending <= 1'b0;
    end else if (en) begin
      data    <= nxt;
      pending <= busy[addr] && !hit;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending-write scoreboard and registered read ports
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = aw(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic            wr_ok, iss_ok, waw;
  assign wr_ok  = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == AW'(ZERO_ADDR));
  assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == AW'(ZERO_ADDR));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end
  // flush beats issue, issue beats writeback to the same register
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREG; r++)
      busy_nxt[r] = bus.flush ? 1'b0 :
                    (iss_ok && bus.iss_addr == AW'(r)) ? 1'b1 :
                    (bus.wr_en && bus.wr_addr == AW'(r)) ? 1'b0 : busy[r];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      waw  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      waw  <= iss_ok && !bus.flush && busy[bus.iss_addr] && !(bus.wr_en && bus.wr_addr == bus.iss_addr);
    end
  end
  assign bus.busy_vec = busy;
  assign bus.waw_err  = waw;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rdport #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rd (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.rd_en[i]),
      .addr    (bus.rd_addr[i*AW +: AW]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .regs    (regs),
      .busy    (busy),
      .data    (bus.rd_data[i*XLEN +: XLEN]),
      .pending (bus.rd_pending[i])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random stimulus against a behavioural register file/scoreboard model
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_scoreboard_if #(.XLEN(32), .NREG(32), .NUM_RD(3)) bus();
  regfile_scoreboard #(.XLEN(32), .NREG(32), .NUM_RD(3), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  logic [2:0]  rd_en;
  logic [4:0]  ra [3];
  logic        wr_en, iss_en, flush;
  logic [4:0]  wa, ia;
  logic [31:0] wd;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = {ra[2], ra[1], ra[0]};
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wa;
  assign bus.wr_data  = wd;
  assign bus.iss_en   = iss_en;
  assign bus.iss_addr = ia;
  assign bus.flush    = flush;
  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  logic [31:0] mdata [3];
  logic        mpend [3];
  logic        mwaw;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rd_en = '0; wr_en = 0; iss_en = 0; flush = 0;
    wa = 0; ia = 0; wd = 0;
    for (int i = 0; i < 3; i++) ra[i] = 0;
  endtask
  task automatic model_reset();
    for (int r = 0; r < 32; r++) mregs[r] = 0;
    mbusy = 0; mwaw = 0;
    for (int i = 0; i < 3; i++) begin mdata[i] = 0; mpend[i] = 0; end
  endtask
  task automatic compare_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.data%0d", tag, i), bus.rd_data[i*32 +: 32], mdata[i]);
      check($sformatf("%s.pend%0d", tag, i), 32'(bus.rd_pending[i]), 32'(mpend[i]));
    end
    check($sformatf("%s.busy", tag), bus.busy_vec, mbusy);
    check($sformatf("%s.waw", tag), 32'(bus.waw_err), 32'(mwaw));
  endtask
  // model one clock: reads see pre-edge array, writeback bypass and pending from pre-edge scoreboard
  task automatic step(input string tag);
    logic [31:0] nb;
    for (int i = 0; i < 3; i++) if (rd_en[i]) begin
      mdata[i] = (ra[i] == 0) ? 32'h0 : (wr_en && wa == ra[i]) ? wd : mregs[ra[i]];
      mpend[i] = mbusy[ra[i]] && !(wr_en && wa == ra[i]);
    end
    mwaw = iss_en && !flush && ia != 0 && mbusy[ia] && !(wr_en && wa == ia);
    nb = mbusy;
    if (flush) nb = 0;
    else begin
      if (wr_en) nb[wa] = 0;
      if (iss_en && ia != 0) nb[ia] = 1;
    end
    mbusy = nb;
    if (wr_en && wa != 0) mregs[wa] = wd;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init.busy", bus.busy_vec, 0);
    check("init.data0", bus.rd_data[31:0], 0);
    rst = 0;
    // reset mid-stream
    wr_en = 1; wa = 5; wd = 32'h0000AAAA; iss_en = 1; ia = 6;
    step("pre_rst");
    idle();
    wr_en = 1; wa = 5; wd = 32'h55555555; rd_en = 3'b111;
    for (int i = 0; i < 3; i++) ra[i] = 5;
    #2 rst = 1;
    #1;
    check("rst.data0", bus.rd_data[31:0], 0);
    check("rst.busy", bus.busy_vec, 0);
    check("rst.waw", 32'(bus.waw_err), 0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    idle();
    rd_en = 3'b111;
    for (int i = 0; i < 3; i++) ra[i] = 5;
    step("rst_rd");
    check("rst.r5", bus.rd_data[31:0], 0);
    // write-through bypass
    idle();
    wr_en = 1; wa = 7; wd = 32'hDEADBEEF; rd_en = 3'b011; ra[0] = 7; ra[1] = 7;
    step("byp");
    check("byp.d0", bus.rd_data[31:0], 32'hDEADBEEF);
    check("byp.d1", bus.rd_data[63:32], 32'hDEADBEEF);
    check("byp.pend", 32'(bus.rd_pending[1:0]), 0);
    // zero register
    idle();
    wr_en = 1; wa = 0; wd = 32'h1234; iss_en = 1; ia = 0;
    step("zero_wr");
    idle();
    rd_en = 3'b111;
    step("zero_rd");
    check("zero.d0", bus.rd_data[31:0], 0);
    check("zero.busy0", 32'(bus.busy_vec[0]), 0);
    check("zero.waw", 32'(bus.waw_err), 0);
    // scoreboard lifecycle
    idle(); iss_en = 1; ia = 3;
    step("sb_iss");
    check("sb.busy3", 32'(bus.busy_vec[3]), 1);
    idle(); rd_en = 3'b001; ra[0] = 3;
    step("sb_rd");
    check("sb.pend", 32'(bus.rd_pending[0]), 1);
    idle(); iss_en = 1; ia = 3;
    step("sb_waw");
    check("sb.waw1", 32'(bus.waw_err), 1);
    idle();
    step("sb_idle");
    check("sb.waw0", 32'(bus.waw_err), 0);
    idle(); wr_en = 1; wa = 3; wd = 32'h33;
    step("sb_wb");
    check("sb.busy3c", 32'(bus.busy_vec[3]), 0);
    // simultaneous issue and writeback, then flush with issue
    idle(); iss_en = 1; ia = 9; wr_en = 1; wa = 9; wd = 32'h99;
    step("sim_iw");
    check("sim.busy9", 32'(bus.busy_vec[9]), 1);
    check("sim.waw", 32'(bus.waw_err), 0);
    idle(); iss_en = 1; ia = 4;
    step("sim_iss4");
    idle(); flush = 1; iss_en = 1; ia = 4;
    step("sim_flush");
    check("flush.busy", bus.busy_vec, 0);
    // port independence
    for (int r = 1; r <= 3; r++) begin
      idle(); wr_en = 1; wa = 5'(r); wd = 32'h100 + 32'(r);
      step("pi_wr");
    end
    idle(); rd_en = 3'b111; ra[0] = 1; ra[1] = 2; ra[2] = 3;
    step("pi_rd");
    idle(); rd_en = 3'b101; ra[0] = 4; ra[1] = 5; ra[2] = 6;
    step("pi_hold");
    check("pi.p1", bus.rd_data[63:32], 32'h102);
    check("pi.p0", bus.rd_data[31:0], 32'h0);
    // random traffic, small address range on writeback/issue to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rd_en  = 3'($urandom);
      for (int i = 0; i < 3; i++) ra[i] = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_en  = 1'($urandom);
      wa     = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd     = $urandom;
      iss_en = 1'($urandom);
      ia     = 5'($urandom_range(0, 7));
      flush  = ($urandom % 16) == 0;
      step("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
